// File: rtl/turbosim_sched_if.sv
// rtl/turbosim_sched_if.sv - host bus bundle for turbosim_sched (stats ports under TURBOSIM_SCHED_STATS_EN)
interface turbosim_sched_if #(
    parameter int VAL_WD    = 2,
    parameter int IDX_WD    = 14,
    parameter int TIME_WD   = 16,
    parameter int EVQ_DEPTH = 16
);
    localparam int REC_WD = VAL_WD + IDX_WD + TIME_WD;
    localparam int CNT_WD = $clog2(EVQ_DEPTH) + 1;

    logic                go;
    logic                done;
    logic                wr;
    logic                full;
    logic [REC_WD-1:0]   in_record;
    logic                rd;
    logic                empty;
    logic [REC_WD-1:0]   out_record;
    logic [TIME_WD-1:0]  sim_time;
    logic [CNT_WD-1:0]   evq_count;
`ifdef TURBOSIM_SCHED_STATS_EN
    logic [15:0]         ev_in_cnt;
    logic [15:0]         ev_out_cnt;
    logic [15:0]         stall_cnt;

    modport master (
        output go, wr, in_record, rd,
        input  done, full, empty, out_record, sim_time, evq_count,
        input  ev_in_cnt, ev_out_cnt, stall_cnt
    );
    modport slave (
        input  go, wr, in_record, rd,
        output done, full, empty, out_record, sim_time, evq_count,
        output ev_in_cnt, ev_out_cnt, stall_cnt
    );
`else
    modport master (
        output go, wr, in_record, rd,
        input  done, full, empty, out_record, sim_time, evq_count
    );
    modport slave (
        input  go, wr, in_record, rd,
        output done, full, empty, out_record, sim_time, evq_count
    );
`endif
endinterface

// File: rtl/turbosim_sched.sv
// rtl/turbosim_sched.sv - time-ordered event scheduler: input FIFO -> event buffer -> output FIFO
// Optional saturating activity counters are enabled by defining TURBOSIM_SCHED_STATS_EN.
module turbosim_sched #(
    parameter int VAL_WD    = 2,
    parameter int IDX_WD    = 14,
    parameter int TIME_WD   = 16,
    parameter int IN_DEPTH  = 64,
    parameter int OUT_DEPTH = 8,
    parameter int EVQ_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    turbosim_sched_if.slave  bus
);
    localparam int REC_WD  = VAL_WD + IDX_WD + TIME_WD;
    localparam int SLOT_WD = $clog2(EVQ_DEPTH);
    localparam int CNT_WD  = SLOT_WD + 1;
    localparam int IN_AW   = $clog2(IN_DEPTH);
    localparam int OUT_AW  = $clog2(OUT_DEPTH);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0] state;

    // ---------------- input FIFO ----------------
    logic [REC_WD-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0]  in_wptr, in_rptr;
    logic [IN_AW:0]    in_cnt;
    logic              in_full, in_empty, in_push, in_pop;
    logic [REC_WD-1:0] in_head;

    assign in_full  = (in_cnt == (IN_AW+1)'(IN_DEPTH));
    assign in_empty = (in_cnt == '0);
    assign in_push  = bus.wr && !in_full;
    assign in_head  = in_mem[in_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wptr <= '0;
            in_rptr <= '0;
            in_cnt  <= '0;
        end else begin
            if (in_push) in_wptr <= in_wptr + 1'b1;
            if (in_pop)  in_rptr <= in_rptr + 1'b1;
            in_cnt <= in_cnt + (IN_AW+1)'(in_push) - (IN_AW+1)'(in_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wptr] <= bus.in_record;
    end

    // ---------------- output FIFO (show-ahead) ----------------
    logic [REC_WD-1:0] out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wptr, out_rptr;
    logic [OUT_AW:0]   out_cnt;
    logic              out_full, out_empty, out_push, out_pop;
    logic [REC_WD-1:0] out_din;

    assign out_full  = (out_cnt == (OUT_AW+1)'(OUT_DEPTH));
    assign out_empty = (out_cnt == '0);
    assign out_pop   = bus.rd && !out_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wptr <= '0;
            out_rptr <= '0;
            out_cnt  <= '0;
        end else begin
            if (out_push) out_wptr <= out_wptr + 1'b1;
            if (out_pop)  out_rptr <= out_rptr + 1'b1;
            out_cnt <= out_cnt + (OUT_AW+1)'(out_push) - (OUT_AW+1)'(out_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wptr] <= out_din;
    end

    // ---------------- event buffer ----------------
    logic [EVQ_DEPTH-1:0] slot_valid;
    logic [VAL_WD-1:0]    slot_val  [EVQ_DEPTH];
    logic [IDX_WD-1:0]    slot_idx  [EVQ_DEPTH];
    logic [TIME_WD-1:0]   slot_time [EVQ_DEPTH];

    logic [SLOT_WD-1:0] init_ptr, scan_ptr, free_slot, sel_slot, nx_slot;
    logic [CNT_WD-1:0]  evq_count;
    logic [TIME_WD-1:0] sim_time, sel_time, nx_time;
    logic               sel_found, nx_found, buf_full, load_fire, emit_fire, scan_last, done;

    assign buf_full  = (evq_count == CNT_WD'(EVQ_DEPTH));
    assign load_fire = (state == S_LOAD) && !in_empty && !buf_full;
    assign emit_fire = (state == S_EMIT) && !out_full;
    assign scan_last = (scan_ptr == SLOT_WD'(EVQ_DEPTH - 1));
    assign in_pop    = load_fire;
    assign out_push  = emit_fire;
    assign out_din   = {slot_val[sel_slot], slot_idx[sel_slot], sel_time};

    always_comb begin
        free_slot = '0;
        for (int i = EVQ_DEPTH - 1; i >= 0; i--) begin
            if (!slot_valid[i]) free_slot = SLOT_WD'(i);
        end
    end

    // Running minimum; strict '<' keeps the earlier (lower) slot on ties.
    always_comb begin
        nx_found = (scan_ptr == '0) ? 1'b0 : sel_found;
        nx_slot  = sel_slot;
        nx_time  = sel_time;
        if (slot_valid[scan_ptr] && (!nx_found || slot_time[scan_ptr] < nx_time)) begin
            nx_found = 1'b1;
            nx_slot  = scan_ptr;
            nx_time  = slot_time[scan_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            slot_val[free_slot]  <= in_head[REC_WD-1 -: VAL_WD];
            slot_idx[free_slot]  <= in_head[TIME_WD +: IDX_WD];
            slot_time[free_slot] <= sim_time + in_head[TIME_WD-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INIT;
            done       <= 1'b0;
            init_ptr   <= '0;
            scan_ptr   <= '0;
            sel_found  <= 1'b0;
            sel_slot   <= '0;
            sel_time   <= '0;
            slot_valid <= '0;
            evq_count  <= '0;
            sim_time   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    slot_valid[init_ptr] <= 1'b0;
                    evq_count            <= '0;
                    init_ptr             <= init_ptr + 1'b1;
                    if (init_ptr == SLOT_WD'(EVQ_DEPTH - 1)) begin
                        init_ptr <= '0;
                        done     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.go) begin
                        done  <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    scan_ptr <= '0;
                    if (in_empty || buf_full) begin
                        state <= S_SCAN;
                    end else begin
                        slot_valid[free_slot] <= 1'b1;
                        evq_count             <= evq_count + 1'b1;
                    end
                end
                S_SCAN: begin
                    sel_found <= nx_found;
                    sel_slot  <= nx_slot;
                    sel_time  <= nx_time;
                    scan_ptr  <= scan_ptr + 1'b1;
                    if (scan_last) begin
                        scan_ptr <= '0;
                        if (nx_found)      state <= S_EMIT;
                        else if (in_empty) state <= S_DRAIN;
                        else               state <= S_LOAD;
                    end
                end
                S_EMIT: begin
                    if (!out_full) begin
                        slot_valid[sel_slot] <= 1'b0;
                        sim_time             <= sel_time;
                        evq_count            <= evq_count - 1'b1;
                        state                <= S_SCAN;
                    end
                end
                S_DRAIN: begin
                    if (out_empty) begin
                        done  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.done       = done;
    assign bus.full       = in_full;
    assign bus.empty      = out_empty;
    assign bus.out_record = out_empty ? '0 : out_mem[out_rptr];
    assign bus.sim_time   = sim_time;
    assign bus.evq_count  = evq_count;

`ifdef TURBOSIM_SCHED_STATS_EN
    logic [15:0] ev_in_cnt, ev_out_cnt, stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_in_cnt  <= '0;
            ev_out_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (load_fire && ev_in_cnt != 16'hFFFF)  ev_in_cnt  <= ev_in_cnt + 1'b1;
            if (emit_fire && ev_out_cnt != 16'hFFFF) ev_out_cnt <= ev_out_cnt + 1'b1;
            if (state == S_EMIT && out_full && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.ev_in_cnt  = ev_in_cnt;
    assign bus.ev_out_cnt = ev_out_cnt;
    assign bus.stall_cnt  = stall_cnt;
`endif
endmodule
